// File: rtl/rram_pkg.sv
// rtl/rram_pkg.sv - shared op/state types, voltage selects and op-to-voltage map for the RRAM sequencer
package rram_pkg;

    typedef enum logic [1:0] {
        OP_CSA_RD = 2'b00,
        OP_ADC_RD = 2'b01,
        OP_SET    = 2'b10,
        OP_RESET  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PRECHARGE,
        ST_SENSE,
        ST_PULSE,
        ST_RECOVER,
        ST_RESP
    } state_e;

    localparam logic [3:0] VSEL_V1 = 4'b0001;
    localparam logic [3:0] VSEL_V2 = 4'b0010;
    localparam logic [3:0] VSEL_V3 = 4'b0100;
    localparam logic [3:0] VSEL_V4 = 4'b1000;

    typedef struct packed {
        logic [3:0] wl;
        logic [3:0] bl;
        logic [3:0] sl;
    } vmap_t;

    function automatic vmap_t op_vmap(input op_e op);
        vmap_t m;
        case (op)
            OP_SET:   m = '{wl: VSEL_V3, bl: VSEL_V3, sl: VSEL_V1};
            OP_RESET: m = '{wl: VSEL_V4, bl: VSEL_V1, sl: VSEL_V3};
            default:  m = '{wl: VSEL_V2, bl: VSEL_V1, sl: VSEL_V1};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/rram_array_sequencer_therm2bin.sv
// rtl/rram_array_sequencer_therm2bin.sv - thermometer-to-binary popcount for one ADC column
module rram_therm2bin #(
    parameter int LVLS = 3,
    parameter int CW   = $clog2(LVLS + 1)
) (
    input  logic [LVLS-1:0] therm,
    output logic [CW-1:0]   code
);

    always_comb begin
        code = '0;
        for (int k = 0; k < LVLS; k++) begin
            code = code + CW'(therm[k]);
        end
    end

endmodule

// File: rtl/rram_array_sequencer.sv
// rtl/rram_array_sequencer.sv - RRAM row-operation sequencer; RRAM_VERIFY_EN adds program-and-verify for writes
module rram_array_sequencer
    import rram_pkg::*;
#(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int ADC_LVLS   = 3,
    parameter int PRE_CYC    = 2,
    parameter int SAEN_CYC   = 2,
    parameter int SETTLE_CYC = 1,
`ifdef RRAM_VERIFY_EN
    parameter int MAX_RETRY  = 3,
`endif
    localparam int RW = $clog2(ROWS),
    localparam int CW = $clog2(ADC_LVLS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [RW-1:0]            req_row,
    input  logic [COLS-1:0]          req_colmask,
    input  logic [7:0]               pulse_len,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [COLS*CW-1:0]       rsp_data,
    output logic                     enable_wl,
    output logic                     enable_bl,
    output logic                     enable_sl,
    output logic [3:0]               v_wl,
    output logic [3:0]               v_bl,
    output logic [3:0]               v_sl,
    output logic [ROWS-1:0]          in1_wl,
    output logic [ROWS-1:0]          in0_wl,
    output logic [COLS-1:0]          in1_bl,
    output logic [COLS-1:0]          in0_bl,
    output logic [COLS-1:0]          in1_sl,
    output logic [COLS-1:0]          in0_sl,
    output logic                     enable_csa,
    output logic                     pre,
    output logic                     saen_csa,
    output logic [1:0]               clk_en_adc,
    input  logic [COLS-1:0]          csa,
    input  logic [ADC_LVLS*COLS-1:0] adc_out
);

    state_e            state;
    op_e               op_q;
    logic [COLS-1:0]   mask_q;
    logic [7:0]        plen_q;
    logic [7:0]        cnt;
    logic              sense_phase;
    vmap_t             req_vmap;
    logic [ROWS-1:0]   row_sel;
    logic [COLS-1:0][CW-1:0] adc_code;
    logic [COLS*CW-1:0] sample_data;
    logic [COLS*CW-1:0] wr_data;

`ifdef RRAM_VERIFY_EN
    localparam vmap_t RD_VMAP = op_vmap(OP_CSA_RD);
    logic              verify_q;
    logic [7:0]        retry_q;
    logic [COLS-1:0]   fail_mask;
    vmap_t             wr_vmap;
    assign sense_phase = !op_q[1] || verify_q;
    assign fail_mask   = mask_q & ((op_q == OP_SET) ? ~csa : csa);
    assign wr_vmap     = op_vmap(op_q);
`else
    assign sense_phase = !op_q[1];
`endif

    assign req_vmap = op_vmap(op_e'(req_op));
    assign row_sel  = {{(ROWS-1){1'b0}}, 1'b1} << req_row;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [ADC_LVLS-1:0] therm;
        for (genvar k = 0; k < ADC_LVLS; k++) begin : g_lvl
            assign therm[k] = adc_out[k*COLS + c];
        end
        rram_therm2bin #(.LVLS(ADC_LVLS), .CW(CW)) u_t2b (.therm(therm), .code(adc_code[c]));
    end

    // Write responses report only the columns that never verified (LSB per column).
    always_comb begin
        sample_data = '0;
        wr_data     = '0;
        for (int c = 0; c < COLS; c++) begin
            if (mask_q[c]) begin
                sample_data[c*CW +: CW] = (op_q == OP_ADC_RD) ? adc_code[c] : CW'(csa[c]);
`ifdef RRAM_VERIFY_EN
                wr_data[c*CW] = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_q       <= OP_CSA_RD;
            mask_q     <= '0;
            plen_q     <= 8'd1;
            cnt        <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            enable_wl  <= 1'b0;
            enable_bl  <= 1'b0;
            enable_sl  <= 1'b0;
            enable_csa <= 1'b0;
            pre        <= 1'b0;
            saen_csa   <= 1'b0;
            clk_en_adc <= '0;
            v_wl       <= VSEL_V1;
            v_bl       <= VSEL_V1;
            v_sl       <= VSEL_V1;
            in1_wl     <= '0;
            in0_wl     <= '1;
            in1_bl     <= '0;
            in0_bl     <= '1;
            in1_sl     <= '0;
            in0_sl     <= '1;
`ifdef RRAM_VERIFY_EN
            verify_q   <= 1'b0;
            retry_q    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    op_q      <= op_e'(req_op);
                    mask_q    <= req_colmask;
                    plen_q    <= (pulse_len == 8'd0) ? 8'd1 : pulse_len;
                    cnt       <= 8'(SETTLE_CYC);
                    state     <= ST_SETUP;
                    req_ready <= 1'b0;
                    {v_wl, v_bl, v_sl} <= req_vmap;
                    in1_wl    <= row_sel;
                    in0_wl    <= ~row_sel;
                    in1_bl    <= req_colmask;
                    in0_bl    <= ~req_colmask;
                    in1_sl    <= req_colmask;
                    in0_sl    <= ~req_colmask;
`ifdef RRAM_VERIFY_EN
                    verify_q  <= 1'b0;
                    retry_q   <= '0;
`endif
                end
                ST_SETUP: begin
                    if (cnt > 8'd1) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        {enable_wl, enable_bl, enable_sl} <= 3'b111;
                        if (sense_phase) begin
                            state      <= ST_PRECHARGE;
                            cnt        <= 8'(PRE_CYC);
                            enable_csa <= 1'b1;
                            pre        <= 1'b1;
                        end else begin
                            state <= ST_PULSE;
                            cnt   <= plen_q;
                        end
                    end
                end
                ST_PRECHARGE: begin
                    if (cnt > 8'd1) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state    <= ST_SENSE;
                        cnt      <= 8'(SAEN_CYC);
                        pre      <= 1'b0;
                        saen_csa <= 1'b1;
                        if (op_q == OP_ADC_RD) clk_en_adc <= {(SAEN_CYC == 1), 1'b1};
                    end
                end
                ST_SENSE: begin
                    if (cnt > 8'd1) begin
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd2 && op_q == OP_ADC_RD) clk_en_adc[1] <= 1'b1;
                    end else begin
                        state      <= ST_RECOVER;
                        {enable_wl, enable_bl, enable_sl} <= 3'b000;
                        enable_csa <= 1'b0;
                        saen_csa   <= 1'b0;
                        clk_en_adc <= '0;
`ifdef RRAM_VERIFY_EN
                        if (verify_q) mask_q <= fail_mask;
                        else
`endif
                            rsp_data <= sample_data;
                    end
                end
                ST_PULSE: begin
                    if (cnt > 8'd1) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state <= ST_RECOVER;
                        {enable_wl, enable_bl, enable_sl} <= 3'b000;
                    end
                end
                ST_RECOVER: begin
`ifdef RRAM_VERIFY_EN
                    if (op_q[1] && !verify_q) begin
                        state    <= ST_SETUP;
                        cnt      <= 8'(SETTLE_CYC);
                        verify_q <= 1'b1;
                        {v_wl, v_bl, v_sl} <= RD_VMAP;
                    end else if (op_q[1] && mask_q != '0 && retry_q < 8'(MAX_RETRY)) begin
                        state    <= ST_SETUP;
                        cnt      <= 8'(SETTLE_CYC);
                        verify_q <= 1'b0;
                        retry_q  <= retry_q + 8'd1;
                        {v_wl, v_bl, v_sl} <= wr_vmap;
                        in1_bl   <= mask_q;
                        in0_bl   <= ~mask_q;
                        in1_sl   <= mask_q;
                        in0_sl   <= ~mask_q;
                    end else
`endif
                    begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        v_wl      <= VSEL_V1;
                        v_bl      <= VSEL_V1;
                        v_sl      <= VSEL_V1;
                        in1_wl    <= '0;
                        in0_wl    <= '1;
                        in1_bl    <= '0;
                        in0_bl    <= '1;
                        in1_sl    <= '0;
                        in0_sl    <= '1;
                        if (op_q[1]) rsp_data <= wr_data;
                    end
                end
                ST_RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Break-before-make: voltages must have settled before any driver turns on.
    assert property (@(posedge clk) disable iff (!rst_n)
        ($rose(enable_wl) || $rose(enable_bl) || $rose(enable_sl)) |->
        ($stable(v_wl) && $stable(v_bl) && $stable(v_sl)));

endmodule

// File: doc/rram_array_sequencer.md
Name: rram_array_sequencer

Overview:
- Parametrised digital sequencer driving the RRAM analog macro's WL/BL/SL drivers, current sense amps (CSA) and flash ADC comparators.
- Accepts one row-level operation at a time through a valid/ready request port: CSA read, ADC read, SET pulse or RESET pulse.
- Generates break-before-make driver enables, precharge/sense timing and programmable pulse width, then returns sampled data on a valid/ready response port.
- Generalises the fixed 16x16, 3-comparator macro interface to ROWS x COLS and ADC_LVLS comparators per column.

Parameters:
ROWS, 16, number of word lines
COLS, 16, number of bit/source-line pairs
ADC_LVLS, 3, comparators per column (thermometer levels)
PRE_CYC, 2, precharge cycles (>=1)
SAEN_CYC, 2, sense-enable cycles (>=1)
SETTLE_CYC, 1, cycles from voltage select to driver enable (>=1)
MAX_RETRY, 3, program-verify retry limit (VERIFY_EN only)

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
REQ_VALID  in  1  request valid
REQ_READY  out  1  high only in IDLE
REQ_OP  in  2  00 CSA read, 01 ADC read, 10 SET, 11 RESET
REQ_ROW  in  $clog2(ROWS)  target row
REQ_COLMASK  in  COLS  selected columns
PULSE_LEN  in  8  write pulse cycles; 0 treated as 1
RSP_VALID  out  1  response valid
RSP_READY  in  1  response accept
RSP_DATA  out  COLS*CW  CW=$clog2(ADC_LVLS+1); per-column code, column c at [c*CW +: CW]
ENABLE_WL / ENABLE_BL / ENABLE_SL  out  1 each  driver enables
V_WL / V_BL / V_SL  out  4 each  one-hot select of V1..V4 (bit0=V1)
IN1_WL / IN0_WL  out  ROWS each  row drive select
IN1_BL / IN0_BL / IN1_SL / IN0_SL  out  COLS each  column drive select
ENABLE_CSA, PRE, SAEN_CSA  out  1 each  sense control
CLK_EN_ADC  out  2  bit0 ADC sample, bit1 ADC latch
CSA  in  COLS  sense-amp outputs
ADC_OUT  in  ADC_LVLS*COLS  comparator k of column c at [k*COLS+c]

Behaviour:
- Reset (asynchronous): all enables, PRE, SAEN_CSA, ENABLE_CSA, CLK_EN_ADC and every IN1_* = 0; every IN0_* = all-ones; V_* = 4'b0001; RSP_VALID=0; RSP_DATA=0; FSM=IDLE. Reset mid-operation drops all drivers immediately.
- Request accepted on REQ_VALID&&REQ_READY. Row, mask, op and pulse length are registered; inputs are ignored afterwards.
- FSM states: IDLE -> SETUP -> (read: PRECHARGE -> SENSE) | (write: PULSE) -> RECOVER -> RESP -> IDLE.
- SETUP, SETTLE_CYC cycles:
  - V_* and IN* drive selects are driven; enables stay 0.
  - Selected row gets IN1_WL=1, IN0_WL=0; every other row gets the inverse.
  - Masked columns get IN1=1, IN0=0; unmasked columns get the inverse.
- Voltage map (WL/BL/SL): read V2/V1/V1; SET V3/V3/V1; RESET V4/V1/V3.
- PRECHARGE, PRE_CYC cycles: ENABLE_WL/BL/SL=1, ENABLE_CSA=1, PRE=1.
- SENSE, SAEN_CYC cycles: PRE=0, SAEN_CSA=1.
  - ADC read: CLK_EN_ADC[0]=1 throughout; CLK_EN_ADC[1]=1 on the last cycle.
  - Sampling happens on the last SENSE cycle.
  - CSA read: code = {0..,CSA[c]}.
  - ADC read: code = popcount of the column's comparators.
  - Unmasked columns = 0.
- PULSE, max(PULSE_LEN,1) cycles: ENABLE_WL/BL/SL=1; 8-bit down-counter, no wrap.
- RECOVER, 1 cycle: all enables and sense controls are 0; V_* and IN* keep their values.
- RECOVER -> RESP:
  - RESP asserts RSP_VALID and holds RSP_DATA stable until RSP_READY.
  - V_* return to V1 and IN* to reset values.
  - Write ops return RSP_DATA=0.
- RSP_READY high on entry to RESP gives a 1-cycle RSP_VALID pulse; back-to-back requests incur 1 IDLE cycle minimum.
- Invariant: no enable rises in the same cycle V_* changes. Assertion-checked.

Optional Feature:
- Macro: RRAM_VERIFY_EN.
- With it, SET/RESET run program-and-verify:
  - After RECOVER, perform a CSA read on the remaining mask.
  - Expected result: 1 for SET, 0 for RESET.
  - Failing columns form the new mask; re-pulse while mask nonzero and retries < MAX_RETRY.
  - RSP_DATA column LSB = 1 for columns still failing; bits above are 0.
  - Total latency varies.
- Without it: single pulse; RSP_DATA=0 for writes.

Decomposition:
- Package rram_pkg holds:
  - op enum (OP_CSA_RD, OP_ADC_RD, OP_SET, OP_RESET);
  - FSM state enum;
  - one-hot voltage constants VSEL_V1..VSEL_V4;
  - per-op voltage-map function.
- Sub-module rram_therm2bin, instantiated per column, converts ADC_LVLS thermometer bits to CW-bit popcount.

Test Plan:
- Reset mid-PULSE (SET, PULSE_LEN=20, RST_N low at cycle 10) -> all enables 0 the same cycle, IN0_WL=16'hFFFF, RSP_VALID=0.
- CSA read row 5, mask 16'h00FF, CSA=16'hA5A5 -> IN1_WL=16'h0020; PRE high 2 cycles then SAEN 2 cycles; RSP_DATA column codes 1,0,1,0,0,1,0,1 for cols 0-7, 0 for cols 8-15.
- ADC read, column 3 comparators 3'b011, column 0 3'b111 -> codes 2 and 3; CLK_EN_ADC[1] high exactly 1 cycle.
- RESET row 0, PULSE_LEN=0 -> V_WL=4'b1000, V_SL=4'b0100; enables high exactly 1 cycle; V_* stable one cycle before the enable rises.
- RSP_READY held low 5 cycles -> RSP_VALID and RSP_DATA stable, REQ_READY=0; accepted on cycle 6, REQ_READY=1 next cycle.
- RRAM_VERIFY_EN: SET mask 16'h0003, column 1 CSA stuck 0 -> 1+MAX_RETRY=4 pulses total, final pulse mask 16'h0002, RSP_DATA col1 LSB=1, col0=0.
